depacketizer_vc: RTL and testbench

DEPACKETIZER_VC -- requirements
Module: depacketizer_vc

---
 rtl/depacketizer_vc_if.sv | 27 ++
 rtl/depacketizer_vc.sv | 131 +++++++++++++
 tb/tb_depacketizer_vc.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/depacketizer_vc_if.sv
// depacketizer_vc_if: flit input and reassembled-word output channels of depacketizer_vc.
// master = NoC/downstream side, slave = depacketizer side.
interface depacketizer_vc_if #(
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned WIDTH_IN         = 36,
  parameter int unsigned WIDTH_OUT        = 64
) ();
  logic [WIDTH_IN-1:0]         data_in;
  logic                        valid_in;
  logic                        ready_out;
  logic [WIDTH_OUT-1:0]        data_out;
  logic [ADDRESS_WIDTH-1:0]    dst_out;
  logic [VC_ADDRESS_WIDTH-1:0] vc_out;
  logic                        valid_out;
  logic                        ready_in;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, dst_out, vc_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, dst_out, vc_out, valid_out
  );
endinterface

// File: rtl/depacketizer_vc.sv
// depacketizer_vc: reassembles head/body/tail NoC flits into one wide word tagged with dst/vc.
// Define DEPACKETIZER_VC_ERR_EN to add err_count, a saturating count of protocol errors.
module depacketizer_vc #(
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned WIDTH_IN         = 36,
  parameter int unsigned WIDTH_OUT        = 64,
  parameter int unsigned MAX_FLITS        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  depacketizer_vc_if.slave bus
`ifdef DEPACKETIZER_VC_ERR_EN
  ,
  output logic [7:0]       err_count
`endif
);
  localparam int unsigned PH = WIDTH_IN - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int unsigned PB = WIDTH_IN - 3 - VC_ADDRESS_WIDTH;
  localparam int unsigned CW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BODY = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]                  state, state_nxt;
  logic [WIDTH_OUT-1:0]        acc, acc_nxt;
  logic [CW-1:0]               cnt, cnt_nxt, cnt_inc;
  logic [ADDRESS_WIDTH-1:0]    dst_q, dst_nxt;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_nxt;
  logic                        valid_q, ready_q;

  logic                        flit_take, is_head, is_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [ADDRESS_WIDTH-1:0]    f_dst;
  logic [PH-1:0]               f_ph;
  logic [PB-1:0]               f_pb;

  // Flit field decode; flits with the flit-valid bit clear are consumed but never taken.
  assign flit_take = bus.valid_in && ready_q && bus.data_in[WIDTH_IN-1];
  assign is_head   = bus.data_in[WIDTH_IN-2];
  assign is_tail   = bus.data_in[WIDTH_IN-3];
  assign f_vc      = bus.data_in[WIDTH_IN-4 -: VC_ADDRESS_WIDTH];
  assign f_dst     = bus.data_in[WIDTH_IN-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
  assign f_ph      = bus.data_in[PH-1:0];
  assign f_pb      = bus.data_in[PB-1:0];
  assign cnt_inc   = cnt + CW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    dst_nxt   = dst_q;
    vc_nxt    = vc_q;
    unique case (state)
      IDLE, BODY: begin
        if (flit_take) begin
          if (is_head) begin
            // A head always (re)starts a packet, discarding any partial one.
            acc_nxt   = WIDTH_OUT'(f_ph);
            dst_nxt   = f_dst;
            vc_nxt    = f_vc;
            cnt_nxt   = CW'(1);
            state_nxt = (is_tail || MAX_FLITS == 1) ? OUT : BODY;
          end else if (state == BODY) begin
            acc_nxt = (acc << PB) | WIDTH_OUT'(f_pb);
            cnt_nxt = cnt_inc;
            if (is_tail || cnt_inc == CW'(MAX_FLITS)) state_nxt = OUT;
          end
        end
      end
      OUT: begin
        if (valid_q && bus.ready_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      dst_q   <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      dst_q   <= dst_nxt;
      vc_q    <= vc_nxt;
      valid_q <= (state_nxt == OUT);
      ready_q <= (state_nxt != OUT);
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = acc;
  assign bus.dst_out   = dst_q;
  assign bus.vc_out    = vc_q;

`ifdef DEPACKETIZER_VC_ERR_EN
  logic err_inc;

  // Error events: stray body flit, restarted packet, or forced termination without tail.
  always_comb begin
    err_inc = 1'b0;
    if (flit_take) begin
      if (state == IDLE)      err_inc = !is_head || (MAX_FLITS == 1 && !is_tail);
      else if (state == BODY) err_inc = is_head || (!is_tail && cnt_inc == CW'(MAX_FLITS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_count <= '0;
    else if (err_inc && err_count != 8'hFF)   err_count <= err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_depacketizer_vc.sv
// tb_depacketizer_vc: directed and random flit streams checked by a scoreboard
// fed from a packet-level reference model of the depacketizer.
module tb_depacketizer_vc;
  localparam int unsigned AW   = 4;
  localparam int unsigned VCW  = 1;
  localparam int unsigned WI   = 36;
  localparam int unsigned WO   = 64;
  localparam int unsigned MAXF = 3;
  localparam int unsigned PH   = WI - 3 - VCW - AW;
  localparam int unsigned PB   = WI - 3 - VCW;

  typedef struct {
    logic [WO-1:0]  data;
    logic [AW-1:0]  dst;
    logic [VCW-1:0] vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  depacketizer_vc_if #(.ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VCW),
                       .WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();
`ifdef DEPACKETIZER_VC_ERR_EN
  logic [7:0] err_count;
`endif

  depacketizer_vc #(.ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VCW), .WIDTH_IN(WI),
                    .WIDTH_OUT(WO), .MAX_FLITS(MAXF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DEPACKETIZER_VC_ERR_EN
    , .err_count(err_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: packet payloads collected as a list, expected words queued.
  exp_t        exp_q[$];
  logic [31:0] pl_q[$];
  int          pw_q[$];
  bit          in_pkt = 0;
  bit          busy = 0;
  int          busy_cyc = 0;
  int          model_err = 0;
  logic [AW-1:0]  cur_dst;
  logic [VCW-1:0] cur_vc;

  // Monitor-side state
  int          n_out = 0;
  bit          held = 0;
  exp_t        hold_v;
  exp_t        got;
  logic [WO-1:0]  last_data;
  logic [AW-1:0]  last_dst;
  logic [VCW-1:0] last_vc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WI-1:0] mk(bit fv, bit h, bit t, logic [VCW-1:0] vc,
                                       logic [AW-1:0] dst, logic [31:0] p);
    logic [WI-1:0] f = '0;
    f[WI-1] = fv;
    f[WI-2] = h;
    f[WI-3] = t;
    f[WI-4 -: VCW] = vc;
    if (h) begin
      f[PH +: AW]  = dst;
      f[PH-1:0]    = p[PH-1:0];
    end else begin
      f[PB-1:0]    = p[PB-1:0];
    end
    return f;
  endfunction

  // Word = low WO bits of the bit-concatenation of all payloads, oldest most significant.
  function automatic logic [WO-1:0] assemble();
    logic [WO-1:0] r = '0;
    int pos = 0;
    for (int i = pl_q.size() - 1; i >= 0; i--) begin
      for (int b = 0; b < pw_q[i]; b++) begin
        if (pos < WO) r[pos] = pl_q[i][b];
        pos++;
      end
    end
    return r;
  endfunction

  task automatic bump_err();
    if (model_err < 255) model_err++;
  endtask

  task automatic complete();
    exp_t e;
    e.data = assemble();
    e.dst  = cur_dst;
    e.vc   = cur_vc;
    exp_q.push_back(e);
    in_pkt   = 0;
    busy     = 1;
    busy_cyc = cyc + 1;
  endtask

  task automatic model_accept(input logic [WI-1:0] f);
    if (!f[WI-1]) return;
    if (f[WI-2]) begin
      if (in_pkt) bump_err();
      pl_q.delete();
      pw_q.delete();
      pl_q.push_back(32'(f[PH-1:0]));
      pw_q.push_back(PH);
      cur_dst = f[PH +: AW];
      cur_vc  = f[WI-4 -: VCW];
      in_pkt  = 1;
      if (f[WI-3] || MAXF == 1) begin
        if (!f[WI-3]) bump_err();
        complete();
      end
    end else if (!in_pkt) begin
      bump_err();
    end else begin
      pl_q.push_back(32'(f[PB-1:0]));
      pw_q.push_back(PB);
      if (f[WI-3]) complete();
      else if (pl_q.size() == MAXF) begin
        bump_err();
        complete();
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pl_q.delete();
    pw_q.delete();
    in_pkt    = 0;
    busy      = 0;
    held      = 0;
    model_err = 0;
  endtask

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input bit v, input logic [WI-1:0] f, input bit rdy);
    chk("ready_out", bus.ready_out == !busy, 64'(bus.ready_out), 64'(!busy));
    bus.valid_in = v;
    bus.data_in  = f;
    bus.ready_in = rdy;
    if (v && bus.ready_out) model_accept(f);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n0);
    for (int i = 0; i < 20; i++) begin
      if (n_out > n0) return;
      drive(1'b0, '0, 1'b1);
    end
    chk("out_timeout", 1'b0, 64'(n_out), 64'(n0 + 1));
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Monitor: valid_out timing, hold stability, and scoreboard compare on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("valid_in_reset", bus.valid_out == 1'b0, 64'(bus.valid_out), 64'd0);
    end else begin
      chk("valid_out", bus.valid_out == (busy && cyc >= busy_cyc),
          64'(bus.valid_out), 64'(busy && cyc >= busy_cyc));
      if (bus.valid_out) begin
        if (held)
          chk("hold_stable", {bus.data_out, bus.dst_out, bus.vc_out} == {hold_v.data, hold_v.dst, hold_v.vc},
              bus.data_out, hold_v.data);
        if (bus.ready_in) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1'b0, bus.data_out, 64'd0);
          end else begin
            got = exp_q.pop_front();
            chk("data_out", bus.data_out == got.data, bus.data_out, got.data);
            chk("dst_out", bus.dst_out == got.dst, 64'(bus.dst_out), 64'(got.dst));
            chk("vc_out", bus.vc_out == got.vc, 64'(bus.vc_out), 64'(got.vc));
          end
          last_data = bus.data_out;
          last_dst  = bus.dst_out;
          last_vc   = bus.vc_out;
          n_out++;
          held = 0;
          busy = 0;
        end else begin
          held        = 1;
          hold_v.data = bus.data_out;
          hold_v.dst  = bus.dst_out;
          hold_v.vc   = bus.vc_out;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.ready_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_out", bus.ready_out == 1'b1, 64'(bus.ready_out), 64'd1);
    chk("rst_valid_out", bus.valid_out == 1'b0, 64'(bus.valid_out), 64'd0);
    chk("rst_data_out", bus.data_out == '0, bus.data_out, 64'd0);
    chk("rst_dst_vc", {bus.dst_out, bus.vc_out} == '0, 64'({bus.dst_out, bus.vc_out}), 64'd0);
`ifdef DEPACKETIZER_VC_ERR_EN
    chk("rst_err_count", err_count == 8'd0, 64'(err_count), 64'd0);
`endif
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1);

    // Single-flit packet
    n0 = n_out;
    drive(1'b1, mk(1, 1, 1, 1'b1, 4'd5, 32'h1234567), 1'b1);
    wait_out(n0);
    chk("single_data", last_data == 64'h0000_0000_0123_4567, last_data, 64'h0000_0000_0123_4567);
    chk("single_dst", last_dst == 4'd5, 64'(last_dst), 64'd5);
    chk("single_vc", last_vc == 1'b1, 64'(last_vc), 64'd1);

    // Two-flit packet with downstream stalled for five cycles
    n0 = n_out;
    drive(1'b1, mk(1, 1, 0, 1'b0, 4'd3, 32'h0ABCDEF0), 1'b0);
    drive(1'b1, mk(1, 0, 1, 1'b0, 4'd0, 32'h11223344), 1'b0);
    repeat (5) drive(1'b1, mk(1, 1, 1, 1'b1, 4'd7, 32'h0FFFFFF), 1'b0);
    wait_out(n0);
    chk("two_flit_data", last_data == 64'h0ABC_DEF0_1122_3344, last_data, 64'h0ABC_DEF0_1122_3344);
    chk("two_flit_dst", last_dst == 4'd3, 64'(last_dst), 64'd3);

    // No tail: terminated after MAX_FLITS
    n0 = n_out;
    drive(1'b1, mk(1, 1, 0, 1'b1, 4'd12, 32'h5555555), 1'b1);
    drive(1'b1, mk(1, 0, 0, 1'b1, 4'd0, 32'hDEADBEEF), 1'b1);
    drive(1'b1, mk(1, 0, 0, 1'b1, 4'd0, 32'hCAFEF00D), 1'b1);
    wait_out(n0);
    chk("max_flits_data", last_data == 64'hDEAD_BEEF_CAFE_F00D, last_data, 64'hDEAD_BEEF_CAFE_F00D);
`ifdef DEPACKETIZER_VC_ERR_EN
    chk("err_after_max", err_count == 8'd1, 64'(err_count), 64'd1);
`endif

    // Stray body flit in IDLE, then a head restarting a partial packet
    n0 = n_out;
    drive(1'b1, mk(1, 0, 1, 1'b0, 4'd0, 32'hFFFF0000), 1'b1);
    drive(1'b1, mk(1, 1, 0, 1'b1, 4'd1, 32'h0000001), 1'b1);
    drive(1'b1, mk(1, 0, 0, 1'b1, 4'd0, 32'h00000002), 1'b1);
    drive(1'b1, mk(1, 1, 0, 1'b0, 4'd9, 32'h7654321), 1'b1);
    drive(1'b1, mk(0, 0, 1, 1'b0, 4'd0, 32'h5A5A5A5A), 1'b1);
    drive(1'b1, mk(1, 0, 1, 1'b0, 4'd0, 32'h89ABCDEF), 1'b1);
    wait_out(n0);
    chk("restart_data", last_data == 64'h0765_4321_89AB_CDEF, last_data, 64'h0765_4321_89AB_CDEF);
    chk("restart_dst", last_dst == 4'd9, 64'(last_dst), 64'd9);
    chk("restart_count", n_out == n0 + 1, 64'(n_out), 64'(n0 + 1));
`ifdef DEPACKETIZER_VC_ERR_EN
    chk("err_after_restart", err_count == 8'd3, 64'(err_count), 64'd3);
`endif

    // Reset in the middle of a packet
    n0 = n_out;
    drive(1'b1, mk(1, 1, 0, 1'b0, 4'd4, 32'h1111111), 1'b1);
    drive(1'b1, mk(1, 0, 0, 1'b0, 4'd0, 32'h22222222), 1'b0);
    bus.valid_in = 1'b0;
    pulse_reset(2);
`ifdef DEPACKETIZER_VC_ERR_EN
    chk("err_cleared", err_count == 8'd0, 64'(err_count), 64'd0);
`endif
    drive(1'b1, mk(1, 1, 1, 1'b1, 4'd2, 32'h0000ABC), 1'b1);
    wait_out(n0);
    chk("post_reset_data", last_data == 64'h0000_0000_0000_0ABC, last_data, 64'h0000_0000_0000_0ABC);
    chk("post_reset_count", n_out == n0 + 1, 64'(n_out), 64'(n0 + 1));

    // Random flit stream against the reference model
    for (int i = 0; i < 600; i++) begin
      bit v, fv, h, t, rdy;
      v   = ($urandom % 4) != 0;
      fv  = ($urandom % 8) != 0;
      h   = ($urandom % 3) == 0;
      t   = ($urandom % 3) == 0;
      rdy = ($urandom % 4) != 0;
      drive(v, mk(fv, h, t, VCW'($urandom), AW'($urandom), $urandom), rdy);
    end
    repeat (10) drive(1'b0, '0, 1'b1);
    chk("drain_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
`ifdef DEPACKETIZER_VC_ERR_EN
    chk("err_random", err_count == 8'(model_err), 64'(err_count), 64'(model_err));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
